// File: rtl/joystick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_pkg
//  Purpose  : Shared definitions for the pad scanner: scan state encoding,
//             select-phase constants and button bit indices of the 8-bit
//             pad word (also used by the game core to decode joy1/joy2).
//  Revision : 1.0  initial release
// ============================================================================
package joystick_pkg;

  // Scan sequencer states; each state lasts at least one ce step
  typedef enum logic [1:0] {
    ST_SEL    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_UPDATE = 2'd3
  } scan_state_t;

  // Value driven on the select line for each capture phase
  localparam logic PHASE_H = 1'b1;
  localparam logic PHASE_L = 1'b0;

  // Width of one assembled pad word
  localparam int PAD_BITS = 8;

  // Bit positions inside an assembled pad word (1 = pressed)
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_B     = 4;
  localparam int JOY_C     = 5;
  localparam int JOY_A     = 6;
  localparam int JOY_START = 7;

endpackage
`default_nettype wire

// File: rtl/joystick_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_scan_if
//  Purpose  : Bundles the external shift-chain lines and the decoded pad
//             words. master = scanner side, slave = chain/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface joystick_scan_if;
  import joystick_pkg::*;

  logic                joyCk;   // shift clock to chain, idle low
  logic                joyLd;   // parallel load, active low
  logic                joyS;    // pad select line
  logic                joyD;    // serial data from chain, active-low buttons
  logic [PAD_BITS-1:0] joy1;    // pad1 word, 1 = pressed
  logic [PAD_BITS-1:0] joy2;    // pad2 word, 1 = pressed
  logic                strobe;  // one-clock pulse when joy1/joy2 update

  modport master (
    output joyCk, joyLd, joyS, joy1, joy2, strobe,
    input  joyD
  );

  modport slave (
    input  joyCk, joyLd, joyS, joy1, joy2, strobe,
    output joyD
  );

endinterface
`default_nettype wire

// File: rtl/joystick_map.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_map
//  Purpose  : Combinational remap of one pad's raw H/L phase captures into
//             the 8-bit button word. Bits of the captures that carry no
//             button in a given phase are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module joystick_map
  import joystick_pkg::*;
#(
  parameter int HALF = 8
) (
  input  logic [HALF-1:0]     raw_h,
  input  logic [HALF-1:0]     raw_l,
  output logic [PAD_BITS-1:0] word
);

  // Only k0..k5 (phase H) and k4..k5 (phase L) carry buttons; the rest is
  // folded here so the unused capture bits are explicitly consumed.
  logic unused_bits;
  assign unused_bits = ^{raw_h, raw_l};

  // Assemble the button word from the two select phases
  always_comb begin
    word             = '0;
    word[JOY_UP]     = raw_h[0];
    word[JOY_DOWN]   = raw_h[1];
    word[JOY_LEFT]   = raw_h[2];
    word[JOY_RIGHT]  = raw_h[3];
    word[JOY_B]      = raw_h[4];
    word[JOY_C]      = raw_h[5];
    word[JOY_A]      = raw_l[4];
    word[JOY_START]  = raw_l[5];
  end

endmodule
`default_nettype wire

// File: rtl/joystick_scan.sv
`default_nettype none
// ============================================================================
//  Module   : joystick_scan
//  Purpose  : Scans two Mega Drive style pads through a serial 74HC165-type
//             chain and presents active-high button words joy1/joy2.
//             Sequence per frame (one ce step per transition):
//               SEL(H) LOAD SHIFT(2*BITS) SEL(L) LOAD SHIFT(2*BITS) UPDATE
//             Optional macro JOYSTICK_DEBOUNCE_EN: outputs load only when
//             both assembled words equal those of the previous frame.
//  Revision : 1.0  initial release
// ============================================================================
module joystick_scan
  import joystick_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  joystick_scan_if.master bus
);

  localparam int            HALF   = BITS / 2;
  localparam int            NW     = $clog2(BITS);
  localparam logic [NW-1:0] N_LAST = NW'(BITS - 1);

  scan_state_t         state_q, state_d;
  logic                phase_q, phase_d;
  logic [NW-1:0]       n_q, n_d;
  logic                odd_q, odd_d;
  logic [BITS-1:0]     raw_h_q, raw_h_d;
  logic [BITS-1:0]     raw_l_q, raw_l_d;
  logic                joy_ck_q, joy_ck_d;
  logic                joy_ld_q, joy_ld_d;
  logic                joy_s_q, joy_s_d;
  logic [PAD_BITS-1:0] joy1_q, joy1_d;
  logic [PAD_BITS-1:0] joy2_q, joy2_d;
  logic                strobe_q, strobe_d;
`ifdef JOYSTICK_DEBOUNCE_EN
  logic [PAD_BITS-1:0] prev1_q, prev1_d;
  logic [PAD_BITS-1:0] prev2_q, prev2_d;
`endif

  logic [PAD_BITS-1:0] word1, word2;

  // pad1 is the first half of the chain to come out, pad2 the second
  joystick_map #(.HALF(HALF)) u_map_pad1 (
    .raw_h (raw_h_q[HALF-1:0]),
    .raw_l (raw_l_q[HALF-1:0]),
    .word  (word1)
  );

  joystick_map #(.HALF(HALF)) u_map_pad2 (
    .raw_h (raw_h_q[BITS-1:HALF]),
    .raw_l (raw_l_q[BITS-1:HALF]),
    .word  (word2)
  );

  // Next-state logic; registered outputs are set for the state being entered
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    n_d      = n_q;
    odd_d    = odd_q;
    raw_h_d  = raw_h_q;
    raw_l_d  = raw_l_q;
    joy_ck_d = joy_ck_q;
    joy_ld_d = joy_ld_q;
    joy_s_d  = joy_s_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    strobe_d = 1'b0;
`ifdef JOYSTICK_DEBOUNCE_EN
    prev1_d  = prev1_q;
    prev2_d  = prev2_q;
`endif
    if (ce) begin
      case (state_q)
        ST_SEL: begin
          state_d  = ST_LOAD;
          joy_ld_d = 1'b0;
        end
        ST_LOAD: begin
          state_d  = ST_SHIFT;
          joy_ld_d = 1'b1;
          joy_ck_d = 1'b0;
          n_d      = '0;
          odd_d    = 1'b0;
        end
        ST_SHIFT: begin
          if (!odd_q) begin
            // Data has settled for a whole step with the clock low: sample it
            if (phase_q == PHASE_H) begin
              raw_h_d[n_q] = ~bus.joyD;
            end else begin
              raw_l_d[n_q] = ~bus.joyD;
            end
            odd_d    = 1'b1;
            joy_ck_d = 1'b1;
          end else begin
            odd_d    = 1'b0;
            joy_ck_d = 1'b0;
            if (n_q == N_LAST) begin
              if (phase_q == PHASE_H) begin
                state_d = ST_SEL;
                phase_d = PHASE_L;
                joy_s_d = PHASE_L;
              end else begin
                state_d = ST_UPDATE;
              end
            end else begin
              n_d = n_q + 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          state_d = ST_SEL;
          phase_d = PHASE_H;
          joy_s_d = PHASE_H;
`ifdef JOYSTICK_DEBOUNCE_EN
          prev1_d = word1;
          prev2_d = word2;
          if ((word1 == prev1_q) && (word2 == prev2_q)) begin
            joy1_d   = word1;
            joy2_d   = word2;
            strobe_d = 1'b1;
          end
`else
          joy1_d   = word1;
          joy2_d   = word2;
          strobe_d = 1'b1;
`endif
        end
        default: begin
          state_d = ST_SEL;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SEL;
      phase_q  <= PHASE_H;
      n_q      <= '0;
      odd_q    <= 1'b0;
      raw_h_q  <= '0;
      raw_l_q  <= '0;
      joy_ck_q <= 1'b0;
      joy_ld_q <= 1'b1;
      joy_s_q  <= PHASE_H;
      joy1_q   <= '0;
      joy2_q   <= '0;
      strobe_q <= 1'b0;
`ifdef JOYSTICK_DEBOUNCE_EN
      prev1_q  <= '0;
      prev2_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      n_q      <= n_d;
      odd_q    <= odd_d;
      raw_h_q  <= raw_h_d;
      raw_l_q  <= raw_l_d;
      joy_ck_q <= joy_ck_d;
      joy_ld_q <= joy_ld_d;
      joy_s_q  <= joy_s_d;
      joy1_q   <= joy1_d;
      joy2_q   <= joy2_d;
      strobe_q <= strobe_d;
`ifdef JOYSTICK_DEBOUNCE_EN
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
`endif
    end
  end

  assign bus.joyCk  = joy_ck_q;
  assign bus.joyLd  = joy_ld_q;
  assign bus.joyS   = joy_s_q;
  assign bus.joy1   = joy1_q;
  assign bus.joy2   = joy2_q;
  assign bus.strobe = strobe_q;

endmodule
`default_nettype wire
